// File: rtl/glyph_row_scanner.sv
// Row-multiplexed LED dot-matrix scanner: fetches two glyph rows per row phase from a
// combinational font ROM and drives one-hot rows with static, auto-advance or left-scroll content.
module glyph_row_scanner #(
    parameter int COL_W       = 16,
    parameter int ROW_N       = 16,
    parameter int GLYPH_N     = 4,
    parameter int ADDR_W      = 6,
    parameter int DWELL       = 1000,
    parameter int HOLD_FRAMES = 50,
    localparam int GLYPH_W    = (GLYPH_N > 1) ? $clog2(GLYPH_N) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [1:0]         i_mode,
    input  logic [GLYPH_W-1:0] i_glyph_sel,
    output logic [ADDR_W-1:0]  o_addr,
    input  logic [COL_W-1:0]   i_row,
    output logic [ROW_N-1:0]   o_row_sel,
    output logic [COL_W-1:0]   o_col,
    output logic               o_frame_strobe
);

    localparam int ROW_W   = (ROW_N > 1) ? $clog2(ROW_N) : 1;
    localparam int OFF_W   = (COL_W > 1) ? $clog2(COL_W) : 1;
    localparam int DWELL_W = $clog2(DWELL);
    localparam int FC_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_AUTO   = 2'b01,
        MODE_SCROLL = 2'b10
    } mode_t;

    logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
    logic [ROW_W-1:0]   row_cnt, row_nxt;
    logic [FC_W-1:0]    frame_cnt;
    logic [GLYPH_W-1:0] cur_glyph, nxt_glyph;
    logic [OFF_W-1:0]   offset;
    logic [COL_W-1:0]   cur_buf;
    mode_t              mode_r, mode_in;
    logic               dwell_end, row_wrap, hold_end, mode_chg, step;

    // Visible window of the two adjacent glyph rows shifted left by the scroll offset.
    function automatic logic [COL_W-1:0] scroll_window(input logic [COL_W-1:0] cur,
                                                       input logic [COL_W-1:0] nxt,
                                                       input logic [OFF_W-1:0] off);
        return COL_W'(({cur, nxt} << off) >> COL_W);
    endfunction

    function automatic logic [ROW_N-1:0] row_onehot(input logic [ROW_W-1:0] r);
        return ROW_N'(1) << r;
    endfunction

    always_comb begin
        dwell_end = (dwell_cnt == DWELL_W'(DWELL - 1));
        row_wrap  = i_en && dwell_end && (row_cnt == ROW_W'(ROW_N - 1));
        hold_end  = (frame_cnt == FC_W'(HOLD_FRAMES - 1));
        mode_in   = (i_mode == 2'b11) ? MODE_STATIC : mode_t'(i_mode);
        mode_chg  = (mode_in != mode_r);
        step      = !mode_chg && hold_end;
        nxt_glyph = cur_glyph + 1'b1;
        dwell_nxt = dwell_cnt;
        row_nxt   = row_cnt;
        if (i_en) begin
            if (dwell_end) begin
                dwell_nxt = '0;
                row_nxt   = row_cnt + 1'b1;
            end else begin
                dwell_nxt = dwell_cnt + 1'b1;
            end
        end
        // Dwell 0 fetches the current glyph row; from dwell 1 on the next glyph row stays addressed.
        if (dwell_cnt == '0) o_addr = ADDR_W'({cur_glyph, row_cnt});
        else                 o_addr = ADDR_W'({nxt_glyph, row_cnt});
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dwell_cnt      <= '0;
            row_cnt        <= '0;
            frame_cnt      <= '0;
            cur_glyph      <= '0;
            offset         <= '0;
            mode_r         <= MODE_STATIC;
            o_row_sel      <= '0;
            o_col          <= '0;
            o_frame_strobe <= 1'b0;
        end else begin
            dwell_cnt      <= dwell_nxt;
            row_cnt        <= row_nxt;
            o_frame_strobe <= row_wrap;
            // Row is lit only from dwell 2 to the end of its phase; blanked while paused.
            o_row_sel      <= (i_en && dwell_nxt >= DWELL_W'(2)) ? row_onehot(row_nxt) : '0;
            // The next-glyph word is taken live from the ROM so the row lights at dwell 2.
            if (i_en && dwell_cnt == DWELL_W'(1))
                o_col <= scroll_window(cur_buf, i_row, offset);
            if (row_wrap) begin
                mode_r    <= mode_in;
                frame_cnt <= (mode_chg || hold_end) ? '0 : frame_cnt + 1'b1;
                case (mode_in)
                    MODE_AUTO: begin
                        offset <= '0;
                        if (step) cur_glyph <= nxt_glyph;
                    end
                    MODE_SCROLL: begin
                        if (step) begin
                            if (offset == OFF_W'(COL_W - 1)) begin
                                offset    <= '0;
                                cur_glyph <= nxt_glyph;
                            end else begin
                                offset <= offset + 1'b1;
                            end
                        end
                    end
                    default: begin
                        offset    <= '0;
                        cur_glyph <= i_glyph_sel;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_en && dwell_cnt == '0)
            cur_buf <= i_row;
    end

endmodule

// File: tb/tb_glyph_row_scanner.sv
// Scoreboard bench for glyph_row_scanner: expected row transactions and strobe times are queued
// by the stimulus and checked by an independent monitor as the DUT presents them.
module tb_glyph_row_scanner;

    localparam int COL_W = 16, ROW_N = 16, GLYPH_N = 4, ADDR_W = 6, DWELL = 4, HOLD = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b1;
    logic [1:0]        mode = 2'b00;
    logic [1:0]        sel = 2'b00;
    logic [ADDR_W-1:0] addr;
    logic [COL_W-1:0]  rom, col;
    logic [ROW_N-1:0]  row_sel;
    logic              strobe;

    assign rom = 16'hA000 | {10'd0, addr};
    always #5 clk = ~clk;

    glyph_row_scanner #(
        .COL_W(COL_W), .ROW_N(ROW_N), .GLYPH_N(GLYPH_N), .ADDR_W(ADDR_W),
        .DWELL(DWELL), .HOLD_FRAMES(HOLD)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_glyph_sel(sel),
        .o_addr(addr), .i_row(rom), .o_row_sel(row_sel), .o_col(col), .o_frame_strobe(strobe)
    );

    typedef struct {
        int               key;
        logic [5:0]       a0, a1;
        logic [15:0]      c, rs;
    } tx_t;

    tx_t         exp_q[$];
    int          strobe_q[$];
    int          total = 0, bad = 0, cyc = 0;
    int          m_frame = 0, m_rcnt = 0, m_key = 0;
    logic [15:0] m_last = '0;
    logic [5:0]  h1 = '0, h2 = '0;
    tx_t         m_t;
    int          r1, r2, p;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, expv, cyc);
        end
    endtask

    // Row r of frame f showing glyph g: addresses follow glyph*16+row, next glyph wraps mod 4.
    task automatic push_row(input int f, input int r, input int g, input logic [15:0] c);
        tx_t t;
        t.key = f * ROW_N + r;
        t.a0  = 6'(g * 16 + r);
        t.a1  = 6'(((g + 1) % 4) * 16 + r);
        t.c   = c;
        t.rs  = 16'(1 << r);
        exp_q.push_back(t);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                m_frame = 0;
                m_rcnt  = 0;
                m_last  = '0;
            end else begin
                if (strobe) begin
                    if (strobe_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL strobe_unexpected: got strobe at cyc %0d expected none", cyc);
                    end else begin
                        chk("strobe_cycle", cyc, strobe_q.pop_front());
                    end
                    m_frame++;
                    m_rcnt = 0;
                end
                if (row_sel != '0 && row_sel != m_last) begin
                    m_key  = m_frame * ROW_N + m_rcnt;
                    m_rcnt++;
                    m_last = row_sel;
                    while (exp_q.size() > 0 && exp_q[0].key < m_key) begin
                        m_t = exp_q.pop_front();
                        total++;
                        bad++;
                        $display("FAIL row_missed: got no row for key %0d required one", m_t.key);
                    end
                    if (exp_q.size() > 0 && exp_q[0].key == m_key) begin
                        m_t = exp_q.pop_front();
                        chk("row_addr_cur", h2, m_t.a0);
                        chk("row_addr_nxt", h1, m_t.a1);
                        chk("row_col", col, m_t.c);
                        chk("row_sel", row_sel, m_t.rs);
                    end
                end
            end
            h2 = h1;
            h1 = addr;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_addr", addr, 0);
        chk("reset_row_sel", row_sel, 0);
        chk("reset_col", col, 0);
        chk("reset_strobe", strobe, 0);

        // First run, then a reset asserted at row 7 dwell 2.
        rst_n = 1'b1;
        r1 = cyc;
        push_row(0, 0, 0, 16'hA000);
        push_row(0, 3, 0, 16'hA003);
        wait_until(r1 + 30);
        chk("pre_reset_row7", row_sel, 16'h0080);
        rst_n = 1'b0;
        #1;
        chk("midreset_addr", addr, 0);
        chk("midreset_row_sel", row_sel, 0);
        chk("midreset_col", col, 0);
        chk("midreset_strobe", strobe, 0);
        repeat (3) @(negedge clk);

        // Static glyph 2 takes effect from frame 1; frame 0 still shows glyph 0.
        sel   = 2'd2;
        rst_n = 1'b1;
        r2 = cyc;
        for (int k = 1; k <= 74; k++) strobe_q.push_back(r2 + 64 * k);
        for (int k = 75; k <= 77; k++) strobe_q.push_back(r2 + 64 * k + 20);
        push_row(0, 0, 0, 16'hA000);
        push_row(1, 3, 2, 16'hA023);
        push_row(1, 10, 2, 16'hA02A);
        wait_until(r2 + 76);
        chk("blank_d0_row_sel", row_sel, 0);
        chk("blank_d0_addr", addr, 35);
        chk("blank_d0_col_hold", col, 16'hA022);
        wait_until(r2 + 77);
        chk("blank_d1_row_sel", row_sel, 0);
        chk("blank_d1_addr", addr, 51);
        wait_until(r2 + 78);
        chk("lit_d2_row_sel", row_sel, 16'h0008);

        // Auto mode requested mid-frame 1: frame 1 keeps glyph 2, then 2 frames per glyph.
        wait_until(r2 + 100);
        mode = 2'b01;
        sel  = 2'd1;
        push_row(2, 0, 2, 16'hA020);
        push_row(3, 0, 2, 16'hA020);
        push_row(4, 0, 3, 16'hA030);
        push_row(5, 0, 3, 16'hA030);
        push_row(6, 0, 0, 16'hA000);
        push_row(7, 0, 0, 16'hA000);
        push_row(8, 0, 1, 16'hA010);

        // Scroll from glyph 1: offset o in frames 9+2o and 10+2o.
        wait_until(r2 + 64 * 8 + 30);
        mode = 2'b10;
        push_row(11, 0, 1, 16'h4021);
        push_row(11, 5, 1, 16'h402B);
        push_row(39, 0, 1, 16'h5010);
        push_row(41, 0, 2, 16'hA020);
        push_row(73, 0, 3, 16'hA030);
        push_row(74, 6, 3, 16'hA036);
        push_row(75, 0, 3, 16'h4061);
        push_row(75, 8, 3, 16'h4071);

        // Pause for 20 clocks at row 5 dwell 3 of frame 74.
        p = r2 + 64 * 74 + 23;
        wait_until(p);
        chk("pre_pause_row_sel", row_sel, 16'h0020);
        en = 1'b0;
        wait_until(p + 2);
        chk("pause_row_sel", row_sel, 0);
        chk("pause_addr", addr, 5);
        chk("pause_strobe", strobe, 0);
        chk("pause_col_hold", col, 16'hA035);
        wait_until(p + 20);
        en = 1'b1;

        // Scroll -> static mid-frame 75: frame 75 stays scrolled, frame 76 raw glyph 1.
        wait_until(r2 + 64 * 75 + 20 + 30);
        mode = 2'b00;
        sel  = 2'd1;
        push_row(76, 0, 1, 16'hA010);

        // Mode 11 behaves as static.
        wait_until(r2 + 64 * 76 + 20 + 30);
        mode = 2'b11;
        sel  = 2'd3;
        push_row(77, 0, 3, 16'hA030);

        wait_until(r2 + 64 * 77 + 20 + 30);
        while (exp_q.size() > 0) begin
            m_t = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL row_never_seen: got nothing for key %0d required a row", m_t.key);
        end
        while (strobe_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL strobe_never_seen: got nothing required strobe at cyc %0d", strobe_q.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
